// File: rtl/huffman_bitpacker_if.sv
// +-----------------------------------------------------------------------+
// | huffman_bitpacker_if : code table load, symbol stream and byte stream |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

interface huffman_bitpacker_if #(
  parameter int CNT_W = 16
) ();
  logic             code_valid;
  logic [7:0]       HC1, HC2, HC3, HC4, HC5, HC6;
  logic [7:0]       M1, M2, M3, M4, M5, M6;
  logic             sym_valid;
  logic [7:0]       sym_data;
  logic             sym_last;
  logic             sym_ready;
  logic             out_valid;
  logic [7:0]       out_byte;
  logic             out_ready;
  logic             done;
  logic [CNT_W-1:0] bit_count;
  logic             err;

  modport master (
    output code_valid, HC1, HC2, HC3, HC4, HC5, HC6, M1, M2, M3, M4, M5, M6,
    output sym_valid, sym_data, sym_last, out_ready,
    input  sym_ready, out_valid, out_byte, done, bit_count, err
  );

  modport slave (
    input  code_valid, HC1, HC2, HC3, HC4, HC5, HC6, M1, M2, M3, M4, M5, M6,
    input  sym_valid, sym_data, sym_last, out_ready,
    output sym_ready, out_valid, out_byte, done, bit_count, err
  );
endinterface

`default_nettype wire

// File: rtl/huffman_bitpacker.sv
// +-----------------------------------------------------------------------+
// | huffman_bitpacker : packs per-symbol Huffman codes MSB-first into     |
// | bytes, pads the last partial byte and reports the code bit total.     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module huffman_bitpacker #(
  parameter int   CNT_W   = 16,
  parameter logic PAD_BIT = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  huffman_bitpacker_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_hc  [0:5];
  logic [3:0]       r_len [0:5];
  logic [15:0]      r_acc;
  logic [4:0]       r_fill;
  logic [CNT_W-1:0] r_bit_count;
  logic             r_err;

  logic             w_sym_ready;
  logic             w_push;
  logic             w_legal;
  logic [7:0]       w_code;
  logic [3:0]       w_len;
  logic [3:0]       w_len_eff;
  logic             w_out_valid;
  logic             w_pop;
  logic [4:0]       w_base;
  logic [4:0]       w_shift;
  logic [15:0]      w_place;
  logic [15:0]      w_acc_nxt;
  logic [4:0]       w_fill_nxt;
  logic [7:0]       w_pad_mask;
  logic [CNT_W:0]   w_bc_sum;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  always_comb begin
    w_code  = 8'h00;
    w_len   = 4'd0;
    w_legal = 1'b1;
    case (bus.sym_data)
      8'd1:    begin w_code = r_hc[0]; w_len = r_len[0]; end
      8'd2:    begin w_code = r_hc[1]; w_len = r_len[1]; end
      8'd3:    begin w_code = r_hc[2]; w_len = r_len[2]; end
      8'd4:    begin w_code = r_hc[3]; w_len = r_len[3]; end
      8'd5:    begin w_code = r_hc[4]; w_len = r_len[4]; end
      8'd6:    begin w_code = r_hc[5]; w_len = r_len[5]; end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_sym_ready = (r_state == S_RUN) && (r_fill <= 5'd8);
  assign w_push      = bus.sym_valid && w_sym_ready;
  assign w_len_eff   = (w_push && w_legal) ? w_len : 4'd0;
  assign w_out_valid = ((r_state == S_RUN) && (r_fill >= 5'd8)) ||
                       ((r_state == S_FLUSH) && (r_fill != 5'd0));
  assign w_pop       = w_out_valid && bus.out_ready;

  // A pop of a partial byte (flush only) empties the accumulator entirely.
  assign w_base     = w_pop ? ((r_fill >= 5'd8) ? (r_fill - 5'd8) : 5'd0) : r_fill;
  assign w_shift    = 5'd16 - w_base - {1'b0, w_len_eff};
  assign w_place    = (w_push && w_legal) ? ({8'h00, w_code} << w_shift) : 16'h0000;
  assign w_acc_nxt  = (w_pop ? ((r_fill >= 5'd8) ? (r_acc << 8) : 16'h0000) : r_acc) | w_place;
  assign w_fill_nxt = w_base + {1'b0, w_len_eff};
  assign w_bc_sum   = {1'b0, r_bit_count} + (CNT_W+1)'(w_len_eff);

  assign w_pad_mask = ((r_state == S_FLUSH) && (r_fill < 5'd8)) ? (8'hFF >> r_fill) : 8'h00;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.code_valid) w_state_nxt = S_RUN;
      S_RUN:   if (w_push && bus.sym_last) w_state_nxt = S_FLUSH;
      S_FLUSH: if (w_fill_nxt == 5'd0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 6; i++) begin
        r_hc[i]  <= 8'h00;
        r_len[i] <= 4'd0;
      end
      r_acc       <= 16'h0000;
      r_fill      <= 5'd0;
      r_bit_count <= '0;
      r_err       <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (bus.code_valid) begin
        r_hc[0]     <= bus.HC1 & bus.M1;
        r_hc[1]     <= bus.HC2 & bus.M2;
        r_hc[2]     <= bus.HC3 & bus.M3;
        r_hc[3]     <= bus.HC4 & bus.M4;
        r_hc[4]     <= bus.HC5 & bus.M5;
        r_hc[5]     <= bus.HC6 & bus.M6;
        r_len[0]    <= popcount8(bus.M1);
        r_len[1]    <= popcount8(bus.M2);
        r_len[2]    <= popcount8(bus.M3);
        r_len[3]    <= popcount8(bus.M4);
        r_len[4]    <= popcount8(bus.M5);
        r_len[5]    <= popcount8(bus.M6);
        r_acc       <= 16'h0000;
        r_fill      <= 5'd0;
        r_bit_count <= '0;
        r_err       <= 1'b0;
      end
    end else if ((r_state == S_RUN) || (r_state == S_FLUSH)) begin
      r_acc  <= w_acc_nxt;
      r_fill <= w_fill_nxt;
      if (w_push && !w_legal) r_err <= 1'b1;
      if (w_push && w_legal)
        r_bit_count <= w_bc_sum[CNT_W] ? '1 : w_bc_sum[CNT_W-1:0];
    end
  end

  assign bus.sym_ready = w_sym_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_byte  = PAD_BIT ? (r_acc[15:8] | w_pad_mask) : (r_acc[15:8] & ~w_pad_mask);
  assign bus.done      = (r_state == S_DONE);
  assign bus.bit_count = r_bit_count;
  assign bus.err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_huffman_bitpacker.sv
// +-----------------------------------------------------------------------+
// | tb_huffman_bitpacker : directed self-checking bench for the packer    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_huffman_bitpacker;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  huffman_bitpacker_if #(.CNT_W(16)) bus_if ();

  huffman_bitpacker #(.CNT_W(16), .PAD_BIT(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  got [$];
  int          n_done   = 0;
  logic [15:0] done_bc  = '0;
  logic        done_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Handshakes are sampled mid-cycle; inputs only change just after rising edges.
  always @(negedge clk) begin
    if (bus_if.out_valid && bus_if.out_ready) got.push_back(bus_if.out_byte);
    if (bus_if.done) begin
      n_done++;
      done_bc  = bus_if.bit_count;
      done_err = bus_if.err;
    end
  end

  task automatic load(input logic [47:0] hcs, input logic [47:0] ms);
    {bus_if.HC6, bus_if.HC5, bus_if.HC4, bus_if.HC3, bus_if.HC2, bus_if.HC1} = hcs;
    {bus_if.M6,  bus_if.M5,  bus_if.M4,  bus_if.M3,  bus_if.M2,  bus_if.M1}  = ms;
    bus_if.code_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.code_valid = 1'b0;
  endtask

  task automatic send_sym(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    bus_if.sym_valid = 1'b1;
    bus_if.sym_data  = d;
    bus_if.sym_last  = last;
    @(negedge clk);
    while (!bus_if.sym_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("sym_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus_if.sym_valid = 1'b0;
    bus_if.sym_last  = 1'b0;
  endtask

  task automatic send_basic();
    for (int i = 0; i < 8; i++) send_sym((i % 2 == 0) ? 8'd1 : 8'd2, i == 7);
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (n_done < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 32'(n_done >= target), 32'd1);
    repeat (2) @(negedge clk);
    check("done_single_pulse", n_done, target);
  endtask

  function automatic logic [31:0] byte_at(input int i);
    return (got.size() > i) ? {24'h0, got[i]} : 32'hxxxx_xxxx;
  endfunction

  initial begin
    int d0;
    int n;
    reset = 1'b0;
    bus_if.code_valid = 1'b0;
    {bus_if.HC6, bus_if.HC5, bus_if.HC4, bus_if.HC3, bus_if.HC2, bus_if.HC1} = '0;
    {bus_if.M6,  bus_if.M5,  bus_if.M4,  bus_if.M3,  bus_if.M2,  bus_if.M1}  = '0;
    bus_if.sym_valid = 1'b0;
    bus_if.sym_data  = 8'h00;
    bus_if.sym_last  = 1'b0;
    bus_if.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sym_ready", bus_if.sym_ready, 0);
    check("rst_out_valid", bus_if.out_valid, 0);
    check("rst_out_byte",  bus_if.out_byte,  0);
    check("rst_done",      bus_if.done,      0);
    check("rst_bit_count", bus_if.bit_count, 0);
    check("rst_err",       bus_if.err,       0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Basic packing: "1","01" alternating -> 1011 0110 1101 + pad
    got.delete(); d0 = n_done;
    load(48'h0000_0000_0101, 48'h0000_0000_0301);
    send_basic();
    wait_done(d0 + 1);
    check("basic_nbytes", got.size(), 2);
    check("basic_byte0",  byte_at(0), 32'hB6);
    check("basic_byte1",  byte_at(1), 32'hD0);
    check("basic_bits",   done_bc, 12);
    check("basic_err",    done_err, 0);
    check("basic_bits_held", bus_if.bit_count, 12);

    // Exact byte boundary: no pad byte
    got.delete(); d0 = n_done;
    load(48'h0000_0000_0101, 48'h0000_0000_0301);
    for (int i = 0; i < 8; i++) send_sym(8'd1, i == 7);
    wait_done(d0 + 1);
    check("exact_nbytes", got.size(), 1);
    check("exact_byte0",  byte_at(0), 32'hFF);
    check("exact_bits",   done_bc, 8);

    // Backpressure on the first byte
    got.delete(); d0 = n_done;
    bus_if.out_ready = 1'b0;
    load(48'h0000_0000_0101, 48'h0000_0000_0301);
    fork
      send_basic();
      begin
        n = 0;
        while (!bus_if.out_valid && n < 300) begin
          @(negedge clk);
          n++;
        end
        for (int i = 0; i < 10; i++) begin
          check("bp_valid_held", bus_if.out_valid, 1);
          check("bp_byte_held",  bus_if.out_byte, 8'hB6);
          @(negedge clk);
        end
        check("bp_sym_ready_low", bus_if.sym_ready, 0);
        @(posedge clk); #1;
        bus_if.out_ready = 1'b1;
      end
    join
    wait_done(d0 + 1);
    check("bp_nbytes", got.size(), 2);
    check("bp_byte0",  byte_at(0), 32'hB6);
    check("bp_byte1",  byte_at(1), 32'hD0);
    check("bp_bits",   done_bc, 12);

    // Eight-bit code plus an illegal symbol
    got.delete(); d0 = n_done;
    load(48'h0000_00A5_0101, 48'h0000_00FF_0301);
    send_sym(8'd7, 1'b0);
    send_sym(8'd3, 1'b1);
    wait_done(d0 + 1);
    check("max_nbytes", got.size(), 1);
    check("max_byte0",  byte_at(0), 32'hA5);
    check("max_bits",   done_bc, 8);
    check("max_err",    done_err, 1);
    check("max_err_sticky", bus_if.err, 1);

    // Simultaneous push and pop at fill 8
    got.delete(); d0 = n_done;
    load(48'h0000_0013_053C, 48'h0000_001F_07FF);
    send_sym(8'd1, 1'b0);
    send_sym(8'd2, 1'b0);
    check("pp_fill3_no_valid", bus_if.out_valid, 0);
    check("pp_ready_after",    bus_if.sym_ready, 1);
    check("pp_first_byte",     byte_at(0), 32'h3C);
    send_sym(8'd3, 1'b1);
    wait_done(d0 + 1);
    check("pp_nbytes", got.size(), 2);
    check("pp_byte1",  byte_at(1), 32'hB3);
    check("pp_bits",   done_bc, 16);
    check("pp_err_cleared", done_err, 0);

    // Reset mid-RUN abandons the stream
    got.delete();
    bus_if.out_ready = 1'b0;
    load(48'h0000_0000_0101, 48'h0000_0000_0301);
    send_sym(8'd1, 1'b0);
    send_sym(8'd2, 1'b0);
    send_sym(8'd1, 1'b0);
    reset = 1'b0;
    #1;
    check("mid_rst_sym_ready", bus_if.sym_ready, 0);
    check("mid_rst_out_byte",  bus_if.out_byte,  0);
    check("mid_rst_bit_count", bus_if.bit_count, 0);
    check("mid_rst_done",      bus_if.done,      0);
    repeat (2) @(posedge clk); #1;
    reset = 1'b1;
    bus_if.out_ready = 1'b1;
    bus_if.sym_valid = 1'b1;
    bus_if.sym_data  = 8'd1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_sym_ready", bus_if.sym_ready, 0);
    end
    check("post_rst_out_valid", bus_if.out_valid, 0);
    check("post_rst_nbytes", got.size(), 0);
    bus_if.sym_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/huffman_bitpacker.md
Name: huffman_bitpacker

Overview:
- Downstream of the Huffman code generator.
- Latches the six code words (HC1..HC6) and masks (M1..M6) when code_valid pulses.
- Then consumes a stream of gray symbols (1..6), appends each symbol's code MSB-first into a bit accumulator, and emits packed bytes over a valid/ready interface.
- After the last symbol, pads the final partial byte, then reports the total number of code bits.

Parameters:
- CNT_W, 16: width of bit_count.
- PAD_BIT, 1'b0: value used to fill unused low bits of the final partial byte.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (reset==0 clears all state).
- code_valid  input  1  one-cycle pulse; HC/M inputs valid this cycle.
- HC1..HC6  input  8 each  code word, right-aligned.
- M1..M6  input  8 each  mask, contiguous ones from LSB; code length = popcount(Mk).
- sym_valid  input  1  symbol offered.
- sym_data  input  8  symbol value, legal 1..6.
- sym_last  input  1  qualifies the accepted symbol as final.
- sym_ready  output  1  symbol accepted when sym_valid && sym_ready.
- out_valid  output  1  out_byte valid.
- out_byte  output  8  packed byte, first code bit in bit 7.
- out_ready  input  1  consumer accepts when out_valid && out_ready.
- done  output  1  one-cycle pulse at end of stream.
- bit_count  output  CNT_W  total code bits of the stream; valid when done, held until next LOAD.
- err  output  1  sticky illegal-symbol flag, cleared on LOAD.

Behaviour:
- Reset values:
  - sym_ready=0, out_valid=0, out_byte=0, done=0, bit_count=0, err=0.
  - Tables, accumulator and fill cleared; state=IDLE.
  - Reset mid-operation abandons the stream; no further bytes are emitted.
- States IDLE, RUN, FLUSH, DONE:
  - IDLE: on code_valid, latch HCk, Mk, len_k = popcount(Mk) (0..8); clear bit_count and err; go to RUN next cycle.
  - RUN: accept symbols. An accepted symbol with sym_last=1 goes to FLUSH.
  - FLUSH: drain all bytes; when fill==0 and no byte pending, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- code_valid outside IDLE is ignored.
- Accumulator: 16 bits, MSB-aligned; fill 0..16.
  - sym_ready = (state==RUN) && (fill<=8), from registered fill.
  - Push appends HCk[len_k-1:0] at bit position 15-fill downward: fill += len_k; bit_count += len_k.
- Illegal symbol (0 or >6):
  - Accepted but dropped: no bits, no bit_count change; err<=1.
  - If sym_last is set on it, still go to FLUSH.
  - len_k==0 symbols are accepted with no bits appended.
- Output, RUN: out_valid = (fill>=8); out_byte = acc[15:8].
- Output, FLUSH:
  - out_valid = (fill>0).
  - If fill<8, the low 8-fill bits of out_byte are PAD_BIT.
  - A pop with fill<8 sets fill to 0.
- Pop on out_valid && out_ready: shift acc left 8; fill -= 8 (or to 0 per partial rule).
- Same-cycle push and pop are legal: new bits are written at position 15-(fill-8). Net fill = fill - 8 + len_k.
- While out_valid && !out_ready, out_byte is stable. Pushes only write bits below the fill point.
- bit_count saturates at all ones.
- No byte is emitted for a stream ending on an exact byte boundary beyond the full bytes.
- Latency:
  - The first full byte is valid the cycle after the push that makes fill>=8.
  - done asserts the cycle after the last byte is popped.

Test Plan:
- Basic packing:
  - Stimulus: LOAD HC1=01 M1=01 ("1"), HC2=01 M2=03 ("01"). Stream 1,2,1,2,1,2,1,2 with last on the 8th; out_ready=1.
  - Response: bytes 0xB6 then 0xD0; done pulse; bit_count=12; err=0.
- Exact byte boundary:
  - Stimulus: eight symbol-1s, last on the 8th.
  - Response: single byte 0xFF, no pad byte, bit_count=8.
- Backpressure:
  - Stimulus: basic-packing stream with out_ready=0 for 10 cycles after the first byte appears.
  - Response: out_byte holds 0xB6; sym_ready drops once fill>8; after release, bytes 0xB6, 0xD0 arrive with no loss or duplication.
- Maximum length and illegal symbol:
  - Stimulus: HC3=A5 M3=FF; stream 7, 3 (last).
  - Response: err=1; one byte 0xA5; bit_count=8.
- Reset mid-RUN:
  - Stimulus: drive reset=0 after 3 accepted symbols, then release; offer symbols without code_valid.
  - Response: all outputs at reset values; sym_ready stays 0 until a new code_valid.
- Simultaneous push and pop:
  - Stimulus: fill=8 with a pending byte; push a 3-bit code while out_ready=1.
  - Response: fill becomes 3; the code appears in bits 7:5 of the next byte.
